// File: rtl/ysyx_25060173_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem read at a time
// and hands the fetched word with its PC to decode; honours redirects.
module ysyx_25060173_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        drop;
  logic        active;
  logic [31:0] target;
  logic        unused_bits;

  assign target      = {redirect_pc[31:2], 2'b00};
  assign unused_bits = ^redirect_pc[1:0];

  // active masks the request while reset is held, keeping it a register decode
  assign imem_req_valid = active && (state == S_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == S_OUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      active     <= 1'b0;
      inst       <= 32'h0;
      inst_pc    <= 32'h0;
      inst_fault <= 1'b0;
    end else begin
      active <= 1'b1;
      unique case (state)
        S_REQ: begin
          if (active && imem_req_ready) begin
            state <= S_WAIT;
            drop  <= redirect_valid;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (drop || redirect_valid) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              inst       <= imem_resp_err ? 32'h0 : imem_resp_data;
              inst_pc    <= pc;
              inst_fault <= imem_resp_err;
              state      <= S_OUT;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        S_OUT: begin
          if (inst_ready) pc <= pc + 32'd4;
          if (inst_ready || redirect_valid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
      // a redirect always wins over the sequential advance
      if (redirect_valid) pc <= target;
    end
  end

endmodule

// File: tb/tb_ysyx_25060173_ifu.sv
// Bench for ysyx_25060173_ifu: directed vector table, wrap/reset
// sequence and randomized run against a fetch-order reference model.
module tb_ysyx_25060173_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        a_req_valid, a_inst_valid, a_inst_fault;
  logic [31:0] a_req_addr, a_inst, a_inst_pc;
  logic        b_req_valid, b_inst_valid, b_inst_fault;
  logic [31:0] b_req_addr, b_inst, b_inst_pc;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_25060173_ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(a_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(a_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .inst_valid(a_inst_valid), .inst_ready(inst_ready),
    .inst(a_inst), .inst_pc(a_inst_pc), .inst_fault(a_inst_fault),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  ysyx_25060173_ifu #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req_valid(b_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(b_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .inst_valid(b_inst_valid), .inst_ready(inst_ready),
    .inst(b_inst), .inst_pc(b_inst_pc), .inst_fault(b_inst_fault),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic        rdy, rv, rerr, ir, redir;
    logic [31:0] rdata, rpc;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc, e_inst;
    logic        e_flt;
  } vec_t;

  function automatic vec_t v(
    logic rdy, logic rv, logic rerr, logic [31:0] rdata,
    logic ir, logic redir, logic [31:0] rpc,
    logic e_rv, logic [31:0] e_addr,
    logic e_iv, logic [31:0] e_pc, logic [31:0] e_inst, logic e_flt);
    vec_t r;
    r.rdy = rdy; r.rv = rv; r.rerr = rerr; r.rdata = rdata;
    r.ir = ir; r.redir = redir; r.rpc = rpc;
    r.e_rv = e_rv; r.e_addr = e_addr;
    r.e_iv = e_iv; r.e_pc = e_pc; r.e_inst = e_inst; r.e_flt = e_flt;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    imem_resp_err   = 1'b0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
  endtask

  task automatic chk_reset_a();
    chk("rst_req_valid", a_req_valid, 0);
    chk("rst_req_addr", a_req_addr, 32'h8000_0000);
    chk("rst_inst_valid", a_inst_valid, 0);
    chk("rst_inst", a_inst, 0);
    chk("rst_inst_pc", a_inst_pc, 0);
    chk("rst_inst_fault", a_inst_fault, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    @(posedge clk); #1;
    chk_reset_a();
    @(posedge clk); #1;
    chk_reset_a();
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t vt[$];

  logic [31:0] mpc, paddr, last_data;
  logic [31:0] p_inst, p_pc;
  logic        p_flt, prev_hold, pend, last_err;
  int          cnt, idle, delivered;

  initial begin
    vt.push_back(v(1,0,0,0,            0,0,0, 1,32'h8000_0000, 0,0,0,0));
    vt.push_back(v(0,1,0,32'h9111_1111,0,0,0, 0,0, 0,0,0,0));
    vt.push_back(v(0,0,0,0,            1,0,0, 0,0, 1,32'h8000_0000,32'h9111_1111,0));
    vt.push_back(v(1,0,0,0,            0,0,0, 1,32'h8000_0004, 0,0,0,0));
    vt.push_back(v(0,1,0,32'h9111_1115,0,0,0, 0,0, 0,0,0,0));
    vt.push_back(v(0,0,0,0,            1,0,0, 0,0, 1,32'h8000_0004,32'h9111_1115,0));
    vt.push_back(v(1,0,0,0,            0,0,0, 1,32'h8000_0008, 0,0,0,0));
    vt.push_back(v(0,1,1,32'hDEAD_BEEF,0,0,0, 0,0, 0,0,0,0));
    for (int k = 0; k < 5; k++)
      vt.push_back(v(1,0,0,0,          0,0,0, 0,0, 1,32'h8000_0008,0,1));
    vt.push_back(v(0,0,0,0,            1,0,0, 0,0, 1,32'h8000_0008,0,1));
    vt.push_back(v(0,0,0,0,            0,0,0, 1,32'h8000_000C, 0,0,0,0));
    vt.push_back(v(1,0,0,0,            0,0,0, 1,32'h8000_000C, 0,0,0,0));
    vt.push_back(v(0,0,0,0,            0,1,32'h8000_0103, 0,0, 0,0,0,0));
    vt.push_back(v(0,0,0,0,            0,0,0, 0,0, 0,0,0,0));
    vt.push_back(v(0,1,0,32'h9111_111D,0,0,0, 0,0, 0,0,0,0));
    vt.push_back(v(1,0,0,0,            0,0,0, 1,32'h8000_0100, 0,0,0,0));
    vt.push_back(v(0,1,0,32'h9111_1011,0,0,0, 0,0, 0,0,0,0));
    vt.push_back(v(0,0,0,0,            1,1,32'h8000_0200, 0,0, 1,32'h8000_0100,32'h9111_1011,0));
    vt.push_back(v(1,0,0,0,            0,1,32'h8000_0300, 1,32'h8000_0200, 0,0,0,0));
    vt.push_back(v(0,1,0,32'h9111_1311,0,0,0, 0,0, 0,0,0,0));
    vt.push_back(v(0,0,0,0,            0,1,32'h8000_0404, 1,32'h8000_0300, 0,0,0,0));
    vt.push_back(v(1,0,0,0,            0,0,0, 1,32'h8000_0404, 0,0,0,0));
    vt.push_back(v(0,1,0,32'h9111_1515,0,0,0, 0,0, 0,0,0,0));
    vt.push_back(v(0,0,0,0,            0,1,32'h8000_0010, 0,0, 1,32'h8000_0404,32'h9111_1515,0));
    vt.push_back(v(0,1,0,32'h1234_5678,0,0,0, 1,32'h8000_0010, 0,0,0,0));
    vt.push_back(v(1,0,0,0,            0,0,0, 1,32'h8000_0010, 0,0,0,0));
    vt.push_back(v(0,1,0,32'h9111_1101,0,1,32'h8000_0020, 0,0, 0,0,0,0));
    vt.push_back(v(0,0,0,0,            0,0,0, 1,32'h8000_0020, 0,0,0,0));

    // directed table on the default-reset instance
    do_reset();
    for (int i = 0; i < vt.size(); i++) begin
      imem_req_ready  = vt[i].rdy;
      imem_resp_valid = vt[i].rv;
      imem_resp_err   = vt[i].rerr;
      imem_resp_data  = vt[i].rdata;
      inst_ready      = vt[i].ir;
      redirect_valid  = vt[i].redir;
      redirect_pc     = vt[i].rpc;
      chk($sformatf("v%0d_req_valid", i), a_req_valid, vt[i].e_rv);
      if (vt[i].e_rv) chk($sformatf("v%0d_req_addr", i), a_req_addr, vt[i].e_addr);
      chk($sformatf("v%0d_inst_valid", i), a_inst_valid, vt[i].e_iv);
      if (vt[i].e_iv) begin
        chk($sformatf("v%0d_inst_pc", i), a_inst_pc, vt[i].e_pc);
        chk($sformatf("v%0d_inst", i), a_inst, vt[i].e_inst);
        chk($sformatf("v%0d_inst_fault", i), a_inst_fault, vt[i].e_flt);
      end
      @(posedge clk); #1;
    end

    // wrap-around PC and reset while a request is outstanding
    do_reset();
    imem_req_ready = 1'b1;
    chk("w_req_valid", b_req_valid, 1);
    chk("w_req_addr0", b_req_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hEEEE_EEED;
    chk("w_wait_noreq", b_req_valid, 0);
    @(posedge clk); #1;
    imem_resp_valid = 1'b0;
    inst_ready = 1'b1;
    chk("w_inst_valid", b_inst_valid, 1);
    chk("w_inst_pc", b_inst_pc, 32'hFFFF_FFFC);
    chk("w_inst", b_inst, 32'hEEEE_EEED);
    @(posedge clk); #1;
    inst_ready = 1'b0;
    imem_req_ready = 1'b1;
    chk("w_wrap_valid", b_req_valid, 1);
    chk("w_wrap_addr", b_req_addr, 32'h0000_0000);
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    chk("w_wait2", b_req_valid, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("w_rst_req_valid", b_req_valid, 0);
    chk("w_rst_addr", b_req_addr, 32'hFFFF_FFFC);
    chk("w_rst_inst_valid", b_inst_valid, 0);
    rst = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h5555_5555;
    @(posedge clk); #1;
    chk("w_post_req_valid", b_req_valid, 1);
    chk("w_post_addr", b_req_addr, 32'hFFFF_FFFC);
    chk("w_post_inst_valid", b_inst_valid, 0);
    @(posedge clk); #1;
    imem_resp_valid = 1'b0;
    chk("w_late_ignored", b_inst_valid, 0);
    chk("w_reissue", b_req_valid, 1);

    // randomized run: every request and delivery must follow the
    // architectural PC; delivered words must be mem[pc] or a fault
    do_reset();
    mpc = 32'h8000_0000;
    pend = 1'b0;
    cnt = 0;
    paddr = 32'h0;
    last_err = 1'b0;
    last_data = 32'h0;
    prev_hold = 1'b0;
    p_inst = 32'h0;
    p_pc = 32'h0;
    p_flt = 1'b0;
    idle = 0;
    delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      imem_req_ready  = ($urandom % 4) != 0;
      imem_resp_valid = pend && (cnt == 0);
      imem_resp_err   = imem_resp_valid && (($urandom % 8) == 0);
      imem_resp_data  = (imem_resp_valid && !imem_resp_err) ?
                        (paddr ^ 32'h1111_1111) : $urandom;
      inst_ready      = ($urandom % 3) != 0;
      redirect_valid  = ($urandom % 12) == 0;
      redirect_pc     = $urandom;

      if (a_req_valid) begin
        chk("r_req_addr", a_req_addr, mpc);
        chk("r_one_outstanding", pend, 0);
      end
      if (a_inst_valid) begin
        chk("r_inst_pc", a_inst_pc, mpc);
        chk("r_inst_fault", a_inst_fault, last_err);
        chk("r_inst", a_inst, last_err ? 32'h0 : (mpc ^ 32'h1111_1111));
      end
      if (prev_hold) begin
        chk("r_hold_valid", a_inst_valid, 1);
        chk("r_hold_inst", a_inst, p_inst);
        chk("r_hold_pc", a_inst_pc, p_pc);
        chk("r_hold_fault", a_inst_fault, p_flt);
      end
      if (a_inst_valid && inst_ready && !redirect_valid) begin
        idle = 0;
        delivered++;
      end else begin
        idle++;
      end
      if (idle > 200) begin
        chk("r_progress_timeout", idle, 0);
        break;
      end

      prev_hold = a_inst_valid && !inst_ready && !redirect_valid;
      p_inst = a_inst;
      p_pc = a_inst_pc;
      p_flt = a_inst_fault;
      if (redirect_valid) mpc = {redirect_pc[31:2], 2'b00};
      else if (a_inst_valid && inst_ready) mpc = mpc + 32'd4;
      if (imem_resp_valid) begin
        pend = 1'b0;
        last_err = imem_resp_err;
        last_data = imem_resp_data;
      end else if (pend) begin
        cnt--;
      end
      if (a_req_valid && imem_req_ready) begin
        pend = 1'b1;
        cnt = $urandom_range(0, 2);
        paddr = a_req_addr;
      end
      @(posedge clk); #1;
    end
    if (delivered < 100) chk("r_delivered_count", delivered, 100);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
